// File: rtl/seg7_scan_cnt60.sv
// Two-digit multiplexed common-anode 7-seg driver for a mod-60 counter (frame snapshot, guard, LZ blank, blink).
// Latency: 1 clock from internal scan state to pins; no backpressure (free-running scan, inputs sampled once per frame).
module seg7_scan_cnt60 #(
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 250
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] CNT10,
    input  logic [2:0] CNT6,
    input  logic       BLANK_LZ,
    input  logic       BLINK_EN,
    input  logic       DP_EN,
    output logic [6:0] SEG,
    output logic [1:0] AN,
    output logic       DP
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] r_p;
    logic          r_dig;
    logic [3:0]    r_s10;
    logic [2:0]    r_s6;
    logic [FW-1:0] r_f;
    logic          r_ph;

    logic          w_slot_end;
    logic          w_eof;
    logic          w_dark;
    logic [6:0]    w_seg6;
    logic [1:0]    w_an;
    logic [6:0]    w_seg;
    logic          w_dp;

    function automatic logic [6:0] f_decode(input logic [3:0] v);
        case (v)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h3F;
        endcase
    endfunction

    assign w_slot_end = (r_p == PW'(SCAN_DIV - 1));
    assign w_eof      = w_slot_end && r_dig;
    assign w_dark     = (r_p < PW'(GUARD)) || (BLINK_EN && r_ph);
    // Tens digit is only valid 0-5; 6/7 must show a dash, not their glyphs.
    assign w_seg6     = (r_s6 > 3'd5) ? 7'h3F : f_decode({1'b0, r_s6});

    always_comb begin
        w_an  = 2'b11;
        w_seg = 7'h7F;
        w_dp  = 1'b1;
        if (!w_dark) begin
            if (!r_dig) begin
                w_an  = 2'b10;
                w_seg = f_decode(r_s10);
            end else begin
                w_dp = ~DP_EN;
                if (!(BLANK_LZ && (r_s6 == 3'd0))) begin
                    w_an  = 2'b01;
                    w_seg = w_seg6;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_p   <= '0;
            r_dig <= 1'b0;
            r_s10 <= '0;
            r_s6  <= '0;
            r_f   <= '0;
            r_ph  <= 1'b0;
            SEG   <= 7'h7F;
            AN    <= 2'b11;
            DP    <= 1'b1;
        end else begin
            r_p <= w_slot_end ? '0 : r_p + PW'(1);
            if (w_slot_end) begin
                r_dig <= ~r_dig;
            end
            if (w_eof) begin
                r_s10 <= CNT10;
                r_s6  <= CNT6;
            end
            // Blink counter idles at zero so enabling blink always begins visible.
            if (!BLINK_EN) begin
                r_f  <= '0;
                r_ph <= 1'b0;
            end else if (w_eof) begin
                if (r_f == FW'(BLINK_FRAMES - 1)) begin
                    r_f  <= '0;
                    r_ph <= ~r_ph;
                end else begin
                    r_f <= r_f + FW'(1);
                end
            end
            SEG <= w_seg;
            AN  <= w_an;
            DP  <= w_dp;
        end
    end

endmodule

// File: tb/tb_seg7_scan_cnt60.sv
// Directed bench for seg7_scan_cnt60 with SCAN_DIV=8, GUARD=2, BLINK_FRAMES=3 (16-clock frames).
module tb_seg7_scan_cnt60;

    logic       CLK      = 1'b0;
    logic       RESET    = 1'b0;
    logic [3:0] CNT10    = 4'd0;
    logic [2:0] CNT6     = 3'd0;
    logic       BLANK_LZ = 1'b0;
    logic       BLINK_EN = 1'b0;
    logic       DP_EN    = 1'b0;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic       DP;

    int n_tests = 0;
    int n_fail  = 0;
    // t = scan-state index whose outputs are currently visible (0 = first state after reset release)
    int t = 0;

    seg7_scan_cnt60 #(.SCAN_DIV(8), .GUARD(2), .BLINK_FRAMES(3)) dut (
        .CLK(CLK), .RESET(RESET), .CNT10(CNT10), .CNT6(CNT6),
        .BLANK_LZ(BLANK_LZ), .BLINK_EN(BLINK_EN), .DP_EN(DP_EN),
        .SEG(SEG), .AN(AN), .DP(DP)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic reset_dut();
        RESET = 1'b0;
        repeat (3) tick();
        RESET = 1'b1;
        t = -1;
    endtask

    task automatic test_reset();
        logic [1:0] ea; logic [6:0] es;
        int p, d, f;
        CNT10 = 4'd7; CNT6 = 3'd4; BLANK_LZ = 0; BLINK_EN = 0; DP_EN = 0;
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({AN, SEG, DP} !== {2'b11, 7'h7F, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_hold cyc=%0d: AN=%b SEG=%h DP=%b, expected AN=11 SEG=7f DP=1", i, AN, SEG, DP);
            end
        end
        RESET = 1'b1;
        t = -1;
        for (int i = 0; i < 32; i++) begin
            tick();
            p = t % 8; d = (t / 8) % 2; f = t / 16;
            if (p < 2)       begin ea = 2'b11; es = 7'h7F; end
            else if (d == 0) begin ea = 2'b10; es = (f == 0) ? 7'h40 : 7'h78; end
            else             begin ea = 2'b01; es = (f == 0) ? 7'h40 : 7'h19; end
            n_tests++;
            if ({AN, SEG, DP} !== {ea, es, 1'b1}) begin
                n_fail++;
                $display("FAIL first_frames t=%0d: AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=1", t, AN, SEG, DP, ea, es);
            end
        end
    endtask

    task automatic test_snapshot();
        logic [1:0] ea; logic [6:0] es;
        int p, d, f;
        CNT10 = 4'd3; CNT6 = 3'd4; BLANK_LZ = 0; BLINK_EN = 0; DP_EN = 0;
        reset_dut();
        for (int i = 0; i < 48; i++) begin
            tick();
            p = t % 8; d = (t / 8) % 2; f = t / 16;
            if (p < 2)       begin ea = 2'b11; es = 7'h7F; end
            else if (d == 0) begin ea = 2'b10; es = (f == 0) ? 7'h40 : ((f == 1) ? 7'h30 : 7'h12); end
            else             begin ea = 2'b01; es = (f == 0) ? 7'h40 : 7'h19; end
            n_tests++;
            if ({AN, SEG, DP} !== {ea, es, 1'b1}) begin
                n_fail++;
                $display("FAIL snapshot t=%0d: AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=1", t, AN, SEG, DP, ea, es);
            end
            if (t == 18) CNT10 = 4'd9;
            if (t == 28) CNT10 = 4'd5;
        end
    endtask

    task automatic test_lz_dp();
        logic [1:0] ea; logic [6:0] es; logic ed;
        int p, d, f;
        CNT10 = 4'd9; CNT6 = 3'd0; BLANK_LZ = 1; BLINK_EN = 0; DP_EN = 1;
        reset_dut();
        for (int i = 0; i < 48; i++) begin
            tick();
            p = t % 8; d = (t / 8) % 2; f = t / 16;
            if (p < 2)       begin ea = 2'b11; es = 7'h7F; ed = 1'b1; end
            else if (d == 0) begin ea = 2'b10; es = (f == 0) ? 7'h40 : 7'h10; ed = 1'b1; end
            else if (f < 2)  begin ea = 2'b11; es = 7'h7F; ed = 1'b0; end
            else             begin ea = 2'b01; es = 7'h40; ed = (t <= 42) ? 1'b0 : 1'b1; end
            n_tests++;
            if ({AN, SEG, DP} !== {ea, es, ed}) begin
                n_fail++;
                $display("FAIL lz_dp t=%0d: AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=%b", t, AN, SEG, DP, ea, es, ed);
            end
            if (t == 31) BLANK_LZ = 1'b0;
            if (t == 42) DP_EN = 1'b0;
        end
    endtask

    task automatic test_invalid();
        logic [1:0] ea; logic [6:0] es;
        int p, d, f;
        CNT10 = 4'd12; CNT6 = 3'd7; BLANK_LZ = 0; BLINK_EN = 0; DP_EN = 0;
        reset_dut();
        for (int i = 0; i < 32; i++) begin
            tick();
            p = t % 8; d = (t / 8) % 2; f = t / 16;
            if (p < 2)       begin ea = 2'b11; es = 7'h7F; end
            else if (d == 0) begin ea = 2'b10; es = (f == 0) ? 7'h40 : 7'h3F; end
            else             begin ea = 2'b01; es = (f == 0) ? 7'h40 : 7'h3F; end
            n_tests++;
            if ({AN, SEG, DP} !== {ea, es, 1'b1}) begin
                n_fail++;
                $display("FAIL invalid t=%0d: AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=1", t, AN, SEG, DP, ea, es);
            end
        end
    endtask

    task automatic test_blink();
        logic [1:0] ea; logic [6:0] es;
        int p, d, f;
        bit vis;
        CNT10 = 4'd1; CNT6 = 3'd2; BLANK_LZ = 0; BLINK_EN = 1; DP_EN = 0;
        reset_dut();
        for (int i = 0; i < 152; i++) begin
            tick();
            p = t % 8; d = (t / 8) % 2; f = t / 16;
            vis = (t > 150) || (((f / 3) % 2) == 0);
            if (p < 2 || !vis) begin ea = 2'b11; es = 7'h7F; end
            else if (d == 0)   begin ea = 2'b10; es = (f == 0) ? 7'h40 : 7'h79; end
            else               begin ea = 2'b01; es = (f == 0) ? 7'h40 : 7'h24; end
            n_tests++;
            if ({AN, SEG, DP} !== {ea, es, 1'b1}) begin
                n_fail++;
                $display("FAIL blink t=%0d: AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=1", t, AN, SEG, DP, ea, es);
            end
            if (t == 150) BLINK_EN = 1'b0;
        end
    endtask

    task automatic test_sync_reset();
        logic [1:0] ea; logic [6:0] es;
        int p, d, f;
        CNT10 = 4'd6; CNT6 = 3'd3; BLANK_LZ = 0; BLINK_EN = 0; DP_EN = 0;
        reset_dut();
        repeat (29) tick();
        RESET = 1'b0;
        tick();
        n_tests++;
        if ({AN, SEG, DP} !== {2'b11, 7'h7F, 1'b1}) begin
            n_fail++;
            $display("FAIL midslot_reset: AN=%b SEG=%h DP=%b, expected AN=11 SEG=7f DP=1", AN, SEG, DP);
        end
        RESET = 1'b1;
        t = -1;
        for (int i = 0; i < 22; i++) begin
            tick();
            p = t % 8; d = (t / 8) % 2; f = t / 16;
            if (p < 2)       begin ea = 2'b11; es = 7'h7F; end
            else if (d == 0) begin ea = 2'b10; es = (f == 0) ? 7'h40 : 7'h02; end
            else             begin ea = 2'b01; es = 7'h40; end
            n_tests++;
            if ({AN, SEG, DP} !== {ea, es, 1'b1}) begin
                n_fail++;
                $display("FAIL after_reset t=%0d: AN=%b SEG=%h DP=%b, expected AN=%b SEG=%h DP=1", t, AN, SEG, DP, ea, es);
            end
            if (t == 20) begin
                RESET = 1'b0;
                #3;
                RESET = 1'b1;
            end
        end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_lz_dp();
        test_invalid();
        test_blink();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
